// File: rtl/io_bus_pkg.sv
// Shared types and helpers for the io_bus_bridge: FSM state, read-return steering
// encoding, IO base-address match and channel slice selection.
package io_bus_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   typedef enum logic {
      RD_MEM = 1'b0,
      RD_IO  = 1'b1
   } rd_sel_t;

   localparam int MAX_CH    = 16;
   localparam int MAX_IO_DW = 32;

   // True when addr[15:w] are all ones, i.e. the address lies in the IO window.
   function automatic logic io_base_ones(input logic [15:0] addr, input int w);
      logic ones;
      ones = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i >= w && !addr[i]) ones = 1'b0;
      end
      return ones;
   endfunction

   function automatic logic [MAX_IO_DW-1:0] io_slice(input logic [MAX_CH*MAX_IO_DW-1:0] bus,
                                                     input int ch, input int dw);
      logic [MAX_IO_DW-1:0] s;
      logic [8:0]           idx;
      s = '0;
      for (int i = 0; i < MAX_IO_DW; i++) begin
         idx = 9'(ch * dw + i);
         if (i < dw) s[i] = bus[idx];
      end
      return s;
   endfunction

endpackage

// File: rtl/io_bus_decode.sv
// Combinational address decoder: splits the low 16 address bits into
// {is_io, channel, index}.
module io_bus_decode
   import io_bus_pkg::*;
#(
   parameter int NUM_CHANNELS    = 4,
   parameter int REG_INDEX_WIDTH = 7,
   parameter int CH_BITS         = $clog2(NUM_CHANNELS),
   parameter int CH_W            = (CH_BITS > 0) ? CH_BITS : 1
) (
   input  logic [15:0]                addr,
   output logic                       is_io,
   output logic [CH_W-1:0]            channel,
   output logic [REG_INDEX_WIDTH-1:0] index
);

   localparam int W = CH_BITS + REG_INDEX_WIDTH;

   assign is_io = io_base_ones(addr, W);
   assign index = addr[REG_INDEX_WIDTH-1:0];

   generate
      if (CH_BITS > 0) begin : g_multi
         assign channel = addr[W-1:REG_INDEX_WIDTH];
      end else begin : g_single
         assign channel = '0;
      end
   endgenerate

endmodule

// File: rtl/io_bus_bridge.sv
// Bridges the core memory port to word memory and NUM_CHANNELS ready-handshaked
// IO channels. Define IO_TIMEOUT_EN to enable wait-state timeout and bus_error.
module io_bus_bridge
   import io_bus_pkg::*;
#(
   parameter int WORD_SIZE       = 20,
   parameter int NUM_CHANNELS    = 4,
   parameter int REG_INDEX_WIDTH = 7,
   parameter int IO_DATA_WIDTH   = 16,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [WORD_SIZE-1:0]                  core_addr,
   input  logic                                  core_write_en,
   input  logic [WORD_SIZE-1:0]                  core_write_value,
   output logic [WORD_SIZE-1:0]                  core_read_value,
   output logic                                  core_stall,
   output logic [WORD_SIZE-1:0]                  mem_addr,
   output logic                                  mem_write_en,
   output logic [WORD_SIZE-1:0]                  mem_write_value,
   input  logic [WORD_SIZE-1:0]                  mem_read_value,
   output logic [REG_INDEX_WIDTH-1:0]            io_index,
   output logic [NUM_CHANNELS-1:0]               io_read,
   output logic [NUM_CHANNELS-1:0]               io_write,
   output logic [IO_DATA_WIDTH-1:0]              io_write_value,
   input  logic [NUM_CHANNELS*IO_DATA_WIDTH-1:0] io_read_value,
   input  logic [NUM_CHANNELS-1:0]               io_ready,
   output logic                                  bus_error
);

   localparam int CH_BITS = $clog2(NUM_CHANNELS);
   localparam int CH_W    = (CH_BITS > 0) ? CH_BITS : 1;

   state_t                     state;
   rd_sel_t                    rd_sel;
   logic [IO_DATA_WIDTH-1:0]   rd_hold;
   logic                       dec_io;
   logic [CH_W-1:0]            dec_ch;
   logic                       sel_ready;
   logic                       abort;
   logic [MAX_CH*MAX_IO_DW-1:0] bus_ext;
   logic [IO_DATA_WIDTH-1:0]   rd_slice;
   logic [WORD_SIZE-1:0]       rd_hold_ext;

   io_bus_decode #(
      .NUM_CHANNELS    (NUM_CHANNELS),
      .REG_INDEX_WIDTH (REG_INDEX_WIDTH)
   ) u_decode (
      .addr    (core_addr[15:0]),
      .is_io   (dec_io),
      .channel (dec_ch),
      .index   (io_index)
   );

   assign mem_addr        = core_addr;
   assign mem_write_value = core_write_value;
   assign mem_write_en    = core_write_en && !dec_io;
   assign io_write_value  = core_write_value[IO_DATA_WIDTH-1:0];

   // Only the addressed channel's ready bit is honoured.
   assign sel_ready = io_ready[dec_ch];

`ifdef IO_TIMEOUT_EN
   localparam int TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);

   logic [TO_W-1:0] wait_cnt;
   logic            err_flag;

   assign abort     = (state == WAIT) && dec_io && !sel_ready &&
                      (wait_cnt == TO_W'(TIMEOUT_CYCLES));
   assign bus_error = err_flag;
`else
   localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;

   assign abort     = 1'b0;
   assign bus_error = 1'b0;
`endif

   // Strobes and stall are combinational but forced low while reset is asserted.
   assign core_stall = reset_n && dec_io && !sel_ready && !abort;

   always_comb begin
      io_read  = '0;
      io_write = '0;
      if (reset_n && dec_io && !abort) begin
         if (core_write_en) io_write[dec_ch] = 1'b1;
         else               io_read[dec_ch]  = 1'b1;
      end
   end

   always_comb begin
      bus_ext = '0;
      bus_ext[NUM_CHANNELS*IO_DATA_WIDTH-1:0] = io_read_value;
   end

   assign rd_slice = IO_DATA_WIDTH'(io_slice(bus_ext, int'(dec_ch), IO_DATA_WIDTH));

   always_comb begin
      rd_hold_ext = '0;
      rd_hold_ext[IO_DATA_WIDTH-1:0] = rd_hold;
   end

   assign core_read_value = (rd_sel == RD_IO) ? rd_hold_ext : mem_read_value;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         rd_sel  <= RD_MEM;
         rd_hold <= '0;
`ifdef IO_TIMEOUT_EN
         wait_cnt <= '0;
         err_flag <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (dec_io && !sel_ready) state <= WAIT;
`ifdef IO_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            WAIT: begin
               if (!dec_io || sel_ready || abort) state <= IDLE;
`ifdef IO_TIMEOUT_EN
               wait_cnt <= wait_cnt + 1'b1;
               if (abort) err_flag <= 1'b1;
`endif
            end
            default: state <= IDLE;
         endcase

         // Steering follows the access that completes this cycle; write data never touches rd_hold.
         if (!core_stall) begin
            rd_sel <= (dec_io && !core_write_en) ? RD_IO : RD_MEM;
            if (dec_io && !core_write_en) rd_hold <= abort ? '1 : rd_slice;
         end
      end
   end

endmodule
